// File: rtl/branch_pc_unit_pkg.sv
// ----------------------------------------------------------------------------
// branch_pc_unit_pkg
//   Encodings shared by the PC-sequencing slice.
//   - br_type_t : decoded control-flow type from decode (NONE/BEQ/BNE/JUMP)
//   - state_t   : PC sequencer state (RUN/FLUSH/HALT)
//   - CNT_W     : width of the optional branch statistics counters
// ----------------------------------------------------------------------------
package branch_pc_unit_pkg;

   typedef enum logic [1:0] {
      BR_NONE = 2'b00,
      BR_BEQ  = 2'b01,
      BR_BNE  = 2'b10,
      BR_JUMP = 2'b11
   } br_type_t;

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_FLUSH = 2'b01,
      ST_HALT  = 2'b10
   } state_t;

   localparam int CNT_W = 32;

   // Conditional branches are the only types that consult the comparator.
   function automatic logic is_cond_branch(input br_type_t t);
      return (t == BR_BEQ) || (t == BR_BNE);
   endfunction

endpackage

// File: rtl/branch_pc_unit_target_gen.sv
// ----------------------------------------------------------------------------
// branch_target_gen
//   Purely combinational next-PC datapath for branch_pc_unit.
//   Ports:
//     pc          in  WIDTH  current PC
//     br_type     in  2      decoded control-flow type
//     br_offset   in  WIDTH  signed byte offset (already scaled)
//     jump_target in  WIDTH  absolute JUMP destination
//     seq_pc      out WIDTH  pc + INSTR_BYTES
//     redirect_pc out WIDTH  JUMP -> jump_target, otherwise seq_pc + br_offset
//   All sums wrap modulo 2^WIDTH; the offset is already full width so plain
//   addition gives two's-complement sign extension for free.
// ----------------------------------------------------------------------------
module branch_target_gen
   import branch_pc_unit_pkg::*;
#(
   parameter int WIDTH       = 64,
   parameter int INSTR_BYTES = 4
) (
   input  logic [WIDTH-1:0] pc,
   input  br_type_t         br_type,
   input  logic [WIDTH-1:0] br_offset,
   input  logic [WIDTH-1:0] jump_target,
   output logic [WIDTH-1:0] seq_pc,
   output logic [WIDTH-1:0] redirect_pc
);

   localparam logic [WIDTH-1:0] INC = WIDTH'(INSTR_BYTES);

   logic [WIDTH-1:0] branch_pc;

   assign seq_pc      = pc + INC;
   // Branch target is relative to the sequential PC, not to pc itself.
   assign branch_pc   = seq_pc + br_offset;
   assign redirect_pc = (br_type == BR_JUMP) ? jump_target : branch_pc;

endmodule

// File: rtl/branch_pc_unit.sv
// ----------------------------------------------------------------------------
// branch_pc_unit
//   Owns the architectural PC. Consumes the comparator result plus decoded
//   branch info, selects sequential / branch / jump next-PC, raises a one-cycle
//   fetch flush on every redirect and supports a sticky halt.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     fetch_ready           fetch accepted the instruction at pc this cycle
//     br_valid, br_type     control-flow op present / its type
//     equal, not_equal      comparator outputs
//     br_offset             signed scaled byte offset
//     jump_target           absolute JUMP target
//     halt_req              stop after the current instruction
//     pc                    current PC (registered)
//     flush                 kill the instruction fetched in the redirect shadow
//     halted                core stopped (sticky until reset)
//     cmp_error             1-cycle pulse: equal==not_equal seen on BEQ/BNE
//     taken_cnt/ntaken_cnt  saturating branch statistics
//   Optional feature macro: BRANCH_STATS_EN (adds taken_cnt/ntaken_cnt).
// ----------------------------------------------------------------------------
module branch_pc_unit
   import branch_pc_unit_pkg::*;
#(
   parameter int               WIDTH       = 64,
   parameter logic [WIDTH-1:0] RESET_PC    = '0,
   parameter int               INSTR_BYTES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fetch_ready,
   input  logic             br_valid,
   input  logic [1:0]       br_type,
   input  logic             equal,
   input  logic             not_equal,
   input  logic [WIDTH-1:0] br_offset,
   input  logic [WIDTH-1:0] jump_target,
   input  logic             halt_req,
   output logic [WIDTH-1:0] pc,
   output logic             flush,
   output logic             halted,
`ifdef BRANCH_STATS_EN
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] ntaken_cnt,
`endif
   output logic             cmp_error
);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] pc_reg, pc_next;
   logic             flush_reg, flush_next;
   logic             halted_reg, halted_next;
   logic             cmp_error_reg, cmp_error_next;

   br_type_t         br_type_e;
   logic [WIDTH-1:0] seq_pc;
   logic [WIDTH-1:0] redirect_pc;
   logic             cmp_bad;
   logic             taken;
   logic             accept;

   assign br_type_e = br_type_t'(br_type);

   branch_target_gen #(
      .WIDTH       (WIDTH),
      .INSTR_BYTES (INSTR_BYTES)
   ) u_target_gen (
      .pc          (pc_reg),
      .br_type     (br_type_e),
      .br_offset   (br_offset),
      .jump_target (jump_target),
      .seq_pc      (seq_pc),
      .redirect_pc (redirect_pc)
   );

   // A contradictory comparator result on a conditional branch is flagged and
   // the branch falls through rather than guessing a direction.
   assign cmp_bad = br_valid && is_cond_branch(br_type_e) && (equal == not_equal);
   assign taken   = br_valid && !cmp_bad &&
                    ((br_type_e == BR_JUMP) ||
                     ((br_type_e == BR_BEQ) && equal) ||
                     ((br_type_e == BR_BNE) && not_equal));

   // Instruction actually retires through the sequencer this cycle; a halt
   // request wins, so the instruction it rides on does not execute its branch.
   assign accept  = (state_reg == ST_RUN) && fetch_ready && !halt_req;

   always_comb begin
      state_next     = state_reg;
      pc_next        = pc_reg;
      flush_next     = 1'b0;
      halted_next    = halted_reg;
      cmp_error_next = 1'b0;
      case (state_reg)
         ST_RUN: begin
            if (fetch_ready) begin
               if (halt_req) begin
                  state_next  = ST_HALT;
                  halted_next = 1'b1;
               end else if (taken) begin
                  pc_next    = redirect_pc;
                  state_next = ST_FLUSH;
                  flush_next = 1'b1;
               end else begin
                  pc_next        = seq_pc;
                  cmp_error_next = cmp_bad;
               end
            end
         end
         // Single shadow cycle; fetch_ready is deliberately not consulted.
         ST_FLUSH: state_next = ST_RUN;
         ST_HALT: begin
            state_next  = ST_HALT;
            halted_next = 1'b1;
         end
         default: begin
            state_next = ST_RUN;
            pc_next    = RESET_PC;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_RUN;
         pc_reg        <= RESET_PC;
         flush_reg     <= 1'b0;
         halted_reg    <= 1'b0;
         cmp_error_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         pc_reg        <= pc_next;
         flush_reg     <= flush_next;
         halted_reg    <= halted_next;
         cmp_error_reg <= cmp_error_next;
      end
   end

   assign pc        = pc_reg;
   assign flush     = flush_reg;
   assign halted    = halted_reg;
   assign cmp_error = cmp_error_reg;

`ifdef BRANCH_STATS_EN
   logic [CNT_W-1:0] taken_cnt_reg;
   logic [CNT_W-1:0] ntaken_cnt_reg;
   logic             taken_inc;
   logic             ntaken_inc;

   // NONE is not a branch and never counts; JUMP can only be taken.
   assign taken_inc  = accept && taken;
   assign ntaken_inc = accept && !taken && is_cond_branch(br_type_e) && br_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taken_cnt_reg  <= '0;
         ntaken_cnt_reg <= '0;
      end else begin
         if (taken_inc && (taken_cnt_reg != '1))
            taken_cnt_reg <= taken_cnt_reg + 1'b1;
         if (ntaken_inc && (ntaken_cnt_reg != '1))
            ntaken_cnt_reg <= ntaken_cnt_reg + 1'b1;
      end
   end

   assign taken_cnt  = taken_cnt_reg;
   assign ntaken_cnt = ntaken_cnt_reg;
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
module tb_branch_pc_unit;
   import branch_pc_unit_pkg::*;

   localparam int WIDTH = 64;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             fetch_ready;
   logic             br_valid;
   logic [1:0]       br_type;
   logic             equal;
   logic             not_equal;
   logic [WIDTH-1:0] br_offset;
   logic [WIDTH-1:0] jump_target;
   logic             halt_req;
   logic [WIDTH-1:0] pc;
   logic             flush;
   logic             halted;
   logic             cmp_error;
`ifdef BRANCH_STATS_EN
   logic [31:0]      taken_cnt;
   logic [31:0]      ntaken_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_pc_unit #(
      .WIDTH       (WIDTH),
      .RESET_PC    ('0),
      .INSTR_BYTES (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch_ready (fetch_ready),
      .br_valid    (br_valid),
      .br_type     (br_type),
      .equal       (equal),
      .not_equal   (not_equal),
      .br_offset   (br_offset),
      .jump_target (jump_target),
      .halt_req    (halt_req),
      .pc          (pc),
      .flush       (flush),
      .halted      (halted),
`ifdef BRANCH_STATS_EN
      .taken_cnt   (taken_cnt),
      .ntaken_cnt  (ntaken_cnt),
`endif
      .cmp_error   (cmp_error)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Sample one time unit after the rising edge, then drive new inputs.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One line per transaction: pc/flush/halted/cmp_error against expected.
   task automatic expect_state(input string tag, input logic [63:0] e_pc,
                               input logic e_fl, input logic e_ht, input logic e_ce);
      $display("%0t %s pc=%h flush=%0b halted=%0b cmp_error=%0b", $time, tag, pc, flush, halted, cmp_error);
      check({tag, ".pc"}, pc, e_pc);
      check({tag, ".flush"}, 64'(flush), 64'(e_fl));
      check({tag, ".halted"}, 64'(halted), 64'(e_ht));
      check({tag, ".cmp_error"}, 64'(cmp_error), 64'(e_ce));
   endtask

   task automatic drive(input logic fr, input logic bv, input logic [1:0] bt,
                        input logic eq, input logic ne, input logic [63:0] off,
                        input logic [63:0] tgt, input logic hr);
      fetch_ready = fr; br_valid = bv; br_type = bt; equal = eq; not_equal = ne;
      br_offset = off; jump_target = tgt; halt_req = hr;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 2'b00, 0, 0, 64'd0, 64'd0, 0);
      #12;
      expect_state("reset", 64'd0, 0, 0, 0);
      tick();
      rst_n = 1'b1;

      // Sequential fetch: 0 -> 4 -> 8
      drive(1, 0, 2'b00, 0, 0, 64'd0, 64'd0, 0);
      tick(); expect_state("seq1", 64'd4, 0, 0, 0);
      tick(); expect_state("seq2", 64'd8, 0, 0, 0);

      // BEQ taken from 8 with offset 16 -> 8+4+16 = 28, flush one cycle
      drive(1, 1, 2'b01, 1, 0, 64'd16, 64'd0, 0);
      tick(); expect_state("beq_taken", 64'd28, 1, 0, 0);
      drive(1, 1, 2'b11, 0, 0, 64'd0, 64'h500, 0);   // ignored in FLUSH
      tick(); expect_state("beq_shadow", 64'd28, 0, 0, 0);
      drive(1, 0, 2'b00, 0, 0, 64'd0, 64'd0, 0);
      tick(); expect_state("after_flush", 64'd32, 0, 0, 0);

      // BNE with equal=1 falls through
      drive(1, 1, 2'b10, 1, 0, 64'd64, 64'd0, 0);
      tick(); expect_state("bne_ntaken", 64'd36, 0, 0, 0);

      // JUMP to 0x100; FLUSH ends even with fetch_ready low
      drive(1, 1, 2'b11, 0, 0, 64'd0, 64'h100, 0);
      tick(); expect_state("jump", 64'h100, 1, 0, 0);
      drive(0, 0, 2'b00, 0, 0, 64'd0, 64'd0, 0);
      tick(); expect_state("jump_shadow", 64'h100, 0, 0, 0);

      // BEQ with equal==not_equal: error pulse, falls through
      drive(1, 1, 2'b01, 1, 1, 64'd32, 64'd0, 0);
      tick(); expect_state("cmp_err", 64'h104, 0, 0, 1);
      // valid/NONE is sequential, no error
      drive(1, 1, 2'b00, 1, 1, 64'd32, 64'd0, 0);
      tick(); expect_state("none_seq", 64'h108, 0, 0, 0);
      // stall
      drive(0, 1, 2'b11, 0, 0, 64'd0, 64'h300, 0);
      tick(); expect_state("stall1", 64'h108, 0, 0, 0);
      tick(); expect_state("stall2", 64'h108, 0, 0, 0);

      // Wrap: jump near top, step across all-ones
      drive(1, 1, 2'b11, 0, 0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 0);
      tick(); expect_state("jump_top", 64'hFFFF_FFFF_FFFF_FFF8, 1, 0, 0);
      drive(1, 0, 2'b00, 0, 0, 64'd0, 64'd0, 0);
      tick(); expect_state("top_shadow", 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0);
      tick(); expect_state("top_seq", 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0);
      tick(); expect_state("wrap", 64'd0, 0, 0, 0);

      // Negative offset: 0 + 4 - 8 wraps to ...FFFC
      drive(1, 1, 2'b10, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 0);
      tick(); expect_state("bne_neg", 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0);
      drive(1, 0, 2'b00, 0, 0, 64'd0, 64'd0, 0);
      tick(); expect_state("neg_shadow", 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0);

      // Halt beats a taken jump; later branches ignored
      drive(1, 1, 2'b11, 0, 0, 64'd0, 64'h200, 1);
      tick(); expect_state("halt", 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 0);
      drive(1, 1, 2'b11, 0, 0, 64'd0, 64'h200, 0);
      tick(); expect_state("halt_sticky", 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 0);

      // Reset out of HALT, then async reset in the middle of FLUSH
      rst_n = 1'b0;
      #1 expect_state("rst_halt", 64'd0, 0, 0, 0);
      rst_n = 1'b1;
      drive(1, 1, 2'b11, 0, 0, 64'd0, 64'h40, 0);
      tick(); expect_state("jump40", 64'h40, 1, 0, 0);
      #2 rst_n = 1'b0;
      #1 expect_state("rst_flush", 64'd0, 0, 0, 0);
      #1 rst_n = 1'b1;
      drive(1, 0, 2'b00, 0, 0, 64'd0, 64'd0, 0);
      tick(); expect_state("post_rst", 64'd4, 0, 0, 0);

`ifdef BRANCH_STATS_EN
      // 2 taken + 1 not-taken (+1 NONE that must not count)
      check("cnt_rst_t", 64'(taken_cnt), 64'd0);
      drive(1, 1, 2'b01, 1, 0, 64'd0, 64'd0, 0); tick();
      drive(1, 0, 2'b00, 0, 0, 64'd0, 64'd0, 0); tick();
      drive(1, 1, 2'b11, 0, 0, 64'd0, 64'h80, 0); tick();
      drive(1, 0, 2'b00, 0, 0, 64'd0, 64'd0, 0); tick();
      drive(1, 1, 2'b10, 1, 0, 64'd0, 64'd0, 0); tick();
      drive(1, 1, 2'b00, 0, 0, 64'd0, 64'd0, 0); tick();
      $display("%0t stats taken=%0d ntaken=%0d", $time, taken_cnt, ntaken_cnt);
      check("cnt_taken", 64'(taken_cnt), 64'd2);
      check("cnt_ntaken", 64'(ntaken_cnt), 64'd1);
      // Saturation
      force dut.taken_cnt_reg = 32'hFFFF_FFFE;
      #1 release dut.taken_cnt_reg;
      drive(1, 1, 2'b11, 0, 0, 64'd0, 64'h80, 0); tick();
      check("cnt_max", 64'(taken_cnt), 64'hFFFF_FFFF);
      drive(1, 1, 2'b11, 0, 0, 64'd0, 64'h80, 0); tick();  // FLUSH, no count
      drive(1, 1, 2'b11, 0, 0, 64'd0, 64'h80, 0); tick();
      $display("%0t stats_sat taken=%h", $time, taken_cnt);
      check("cnt_sat", 64'(taken_cnt), 64'hFFFF_FFFF);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
